// File: rtl/sum_uart_tx.sv
// Serial transmitter for 9-bit adder results ({carry, byte}), sent LSB-first as a UART frame.
// Define SUM_TX_PARITY_EN to insert an even-parity bit between the payload and the stop bit.
module sum_uart_tx #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic       sum_valid,
  input  logic [7:0] sum_data,
  input  logic       sum_carry,
  output logic       sum_ready,
  output logic       tx,
  output logic       busy
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_STOP   = 3'd4;
`ifdef SUM_TX_PARITY_EN
  localparam logic [2:0] S_PARITY = 3'd3;
`endif
  localparam logic [7:0] BAUD_LAST = 8'(CLKS_PER_BIT - 1);

  logic [2:0] state;
  logic [7:0] baud_cnt;
  logic [3:0] bit_cnt;
  logic       hold_full;
  logic [8:0] hold_word;
  logic [8:0] shift_reg;
  logic       bit_last;
  logic       accept;
  logic       transfer;
`ifdef SUM_TX_PARITY_EN
  logic       parity_bit;

  function automatic logic even_parity(input logic [8:0] w);
    return ^w;
  endfunction
`endif

  assign sum_ready = ~hold_full & ena;
  assign accept    = sum_valid & sum_ready;
  assign bit_last  = (baud_cnt == BAUD_LAST);
  // A held word moves into the shifter from IDLE or on the final STOP cycle.
  assign transfer  = hold_full & ena &
                     ((state == S_IDLE) | ((state == S_STOP) & bit_last));
  assign busy      = (state != S_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      baud_cnt  <= 8'd0;
      bit_cnt   <= 4'd0;
      hold_full <= 1'b0;
    end else begin
      if (accept)
        hold_full <= 1'b1;
      else if (transfer)
        hold_full <= 1'b0;

      case (state)
        S_IDLE: begin
          baud_cnt <= 8'd0;
          if (transfer) state <= S_START;
        end
        S_START: begin
          if (bit_last) begin
            state    <= S_DATA;
            baud_cnt <= 8'd0;
            bit_cnt  <= 4'd0;
          end else begin
            baud_cnt <= baud_cnt + 8'd1;
          end
        end
        S_DATA: begin
          if (bit_last) begin
            baud_cnt <= 8'd0;
            if (bit_cnt == 4'd8) begin
`ifdef SUM_TX_PARITY_EN
              state <= S_PARITY;
`else
              state <= S_STOP;
`endif
            end else begin
              bit_cnt <= bit_cnt + 4'd1;
            end
          end else begin
            baud_cnt <= baud_cnt + 8'd1;
          end
        end
`ifdef SUM_TX_PARITY_EN
        S_PARITY: begin
          if (bit_last) begin
            state    <= S_STOP;
            baud_cnt <= 8'd0;
          end else begin
            baud_cnt <= baud_cnt + 8'd1;
          end
        end
`endif
        S_STOP: begin
          if (bit_last) begin
            baud_cnt <= 8'd0;
            state    <= transfer ? S_START : S_IDLE;
          end else begin
            baud_cnt <= baud_cnt + 8'd1;
          end
        end
        default: begin
          state    <= S_IDLE;
          baud_cnt <= 8'd0;
        end
      endcase
    end
  end

  // Payload registers carry no reset; they are only observed once a frame is under way.
  always_ff @(posedge clk) begin
    if (accept)
      hold_word <= {sum_carry, sum_data};
    if (transfer) begin
      shift_reg  <= hold_word;
`ifdef SUM_TX_PARITY_EN
      parity_bit <= even_parity(hold_word);
`endif
    end else if ((state == S_DATA) && bit_last) begin
      shift_reg <= {1'b0, shift_reg[8:1]};
    end
  end

  always_comb begin
    tx = 1'b1;
    case (state)
      S_START:  tx = 1'b0;
      S_DATA:   tx = shift_reg[0];
`ifdef SUM_TX_PARITY_EN
      S_PARITY: tx = parity_bit;
`endif
      default:  tx = 1'b1;
    endcase
  end

endmodule
